objects_mux_layered: RTL

//  Parametrised successor of the fixed 3-input objects mux. Selects the highest-priority

---
 rtl/objects_mux_pkg.sv | 23 ++
 rtl/layer_priority_enc.sv | 23 ++
 rtl/objects_mux_layered.sv | 121 ++++++++++++
 3 files changed

// File: rtl/objects_mux_pkg.sv
// Shared types and helpers for the layered RGB332 object multiplexer family.
// Holds the default transparent colour, the layer limit and the colour expander.
package objects_mux_pkg;

  localparam int         MAX_LAYERS      = 16;
  localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;

  typedef logic [3:0] layer_idx_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // MSB replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6],
            c[4:2], c[4:2], c[4:3],
            {4{c[1:0]}}};
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Lowest-index-wins priority encoder over a layer visibility vector.
// Purely combinational; shared by the object multiplexers.
module layer_priority_enc
  import objects_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid,
  output layer_idx_t       idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred.
    valid = |vec;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = layer_idx_t'(i);
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// Layered object multiplexer: picks the highest-priority visible RGB332 layer
// over background, expands to 24-bit colour, handles blinking and collisions.
module objects_mux_layered
  import objects_mux_pkg::*;
#(
  parameter int         NUM_LAYERS   = 8,
  parameter logic [7:0] TRANSPARENT  = TRANSPARENT_RGB,
  parameter int         BLINK_FRAMES = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   layerDrawingRequest,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]   layerEnable,
  input  logic [NUM_LAYERS-1:0]   layerBlink,
  input  logic [7:0]              backGroundRGB,
  output logic [7:0]              redOut,
  output logic [7:0]              greenOut,
  output logic [7:0]              blueOut,
  output logic                    winnerValid,
  output layer_idx_t              winnerIdx,
  output logic [NUM_LAYERS-1:0]   collisionFrame
);

  localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      frame_cnt;
  logic                  blink_phase;
  logic                  frame_wrap;
  logic                  phase_now;
  logic [NUM_LAYERS-1:0] visible;
  logic                  hit;
  logic                  any_visible;
  layer_idx_t            top_idx;
  logic [NUM_LAYERS-1:0] coll_acc;

  logic [7:0]            s1_rgb;
  logic                  s1_valid;
  layer_idx_t            s1_idx;
  rgb888_t               s2_pix;

  // The phase flip applies to the very pixel that carries the wrapping pulse.
  assign frame_wrap = startOfFrame && (frame_cnt == CNT_LAST);
  assign phase_now  = blink_phase ^ frame_wrap;

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and updates together.
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (startOfFrame) begin
      frame_cnt   <= frame_wrap ? '0 : frame_cnt + 1'b1;
      blink_phase <= phase_now;
    end
  end

  always_comb begin
    visible = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      visible[i] = layerDrawingRequest[i] & layerEnable[i]
                 & (layerRGB[8*i +: 8] != TRANSPARENT)
                 & ~(layerBlink[i] & ~phase_now);
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign hit = |(visible & (visible - NUM_LAYERS'(1)));

  layer_priority_enc #(
    .WIDTH (NUM_LAYERS)
  ) u_enc (
    .vec   (visible),
    .valid (any_visible),
    .idx   (top_idx)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_rgb   <= any_visible ? layerRGB[{top_idx, 3'b000} +: 8] : backGroundRGB;
      s1_valid <= any_visible;
      s1_idx   <= any_visible ? top_idx : '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s2_pix      <= '0;
      winnerValid <= 1'b0;
      winnerIdx   <= '0;
    end else begin
      s2_pix      <= rgb888_t'(rgb332_to_rgb888(s1_rgb));
      winnerValid <= s1_valid;
      winnerIdx   <= s1_idx;
    end
  end

  assign redOut   = s2_pix.red;
  assign greenOut = s2_pix.green;
  assign blueOut  = s2_pix.blue;

  // The start-of-frame pixel already belongs to the new frame's accumulation.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_acc       <= '0;
      collisionFrame <= '0;
    end else if (startOfFrame) begin
      collisionFrame <= coll_acc;
      coll_acc       <= hit ? visible : '0;
    end else if (hit) begin
      coll_acc       <= coll_acc | visible;
    end
  end

endmodule
